clock_set_ctrl: RTL and testbench

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_set_ctrl_if.sv | 44 ++++
 rtl/clock_set_ctrl.sv | 152 +++++++++++++++
 tb/tb_clock_set_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/clock_set_ctrl_if.sv
// Bundle of the clock-setting controller's button, time and shadow-value signals.
// The master side is the surrounding clock (buttons, tick, live time); the
// slave side is clock_set_ctrl itself.
interface clock_set_ctrl_if;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic       run_en;
  logic       load;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic [1:0] edit_field;
  logic       blink;

  modport master (
    output tick_1hz,
    output btn_mode,
    output btn_inc,
    output cur_hour,
    output cur_min,
    input  run_en,
    input  load,
    input  set_hour,
    input  set_min,
    input  edit_field,
    input  blink
  );

  modport slave (
    input  tick_1hz,
    input  btn_mode,
    input  btn_inc,
    input  cur_hour,
    input  cur_min,
    output run_en,
    output load,
    output set_hour,
    output set_min,
    output edit_field,
    output blink
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Clock-setting controller: a mode button walks RUN -> hour edit -> minute
// edit -> one-cycle commit; an increment button bumps the field being edited.
// An edit session with no button activity for TIMEOUT_S seconds is abandoned
// without loading. All outputs are registered and follow the next state.
module clock_set_ctrl #(
  parameter int TIMEOUT_S = 30
) (
  input  logic         clk,
  input  logic         rst_n,   // active-high synchronous reset despite the name
  clock_set_ctrl_if.slave bus
);

  localparam int IDLE_W = $clog2(TIMEOUT_S + 1);
  localparam logic [IDLE_W-1:0] TIMEOUT_V = IDLE_W'(TIMEOUT_S);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_COMMIT  = 2'd3
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'b00;
  localparam logic [1:0] FIELD_HOUR = 2'b01;
  localparam logic [1:0] FIELD_MIN  = 2'b10;

  state_t            state_q, state_d;
  logic [4:0]        set_hour_q, set_hour_d;
  logic [5:0]        set_min_q, set_min_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              blink_q, blink_d;
  logic              run_en_q, run_en_d;
  logic              load_q, load_d;
  logic [1:0]        edit_field_q, edit_field_d;
  logic [IDLE_W-1:0] idle_inc;

  // Hour increment with 23 -> 0 wrap; out-of-range values also fold to 0.
  function automatic logic [4:0] inc_hour(input logic [4:0] h);
    return (h >= 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

  // Minute increment with 59 -> 0 wrap; out-of-range values also fold to 0.
  function automatic logic [5:0] inc_min(input logic [5:0] m);
    return (m >= 6'd59) ? 6'd0 : m + 6'd1;
  endfunction

  // Idle counter never exceeds TIMEOUT_S while editing, so this cannot overflow
  // in a way that matters.
  assign idle_inc = idle_q + 1'b1;

  // Next-state, shadow-value, idle/blink and registered-output computation.
  always_comb begin
    state_d    = state_q;
    set_hour_d = set_hour_q;
    set_min_d  = set_min_q;
    idle_d     = idle_q;
    blink_d    = blink_q;

    unique case (state_q)
      ST_RUN: begin
        if (bus.btn_mode) begin
          // Shadow registers snapshot the live time as the session opens.
          state_d    = ST_SET_HR;
          set_hour_d = bus.cur_hour;
          set_min_d  = bus.cur_min;
          idle_d     = '0;
          blink_d    = 1'b0;
        end else if (bus.btn_inc) begin
          idle_d = '0;
        end
      end

      ST_SET_HR: begin
        if (bus.tick_1hz) blink_d = ~blink_q;
        // Buttons take priority over the timeout tick; mode beats inc.
        if (bus.btn_mode) begin
          state_d = ST_SET_MIN;
          idle_d  = '0;
        end else if (bus.btn_inc) begin
          set_hour_d = inc_hour(set_hour_q);
          idle_d     = '0;
        end else if (bus.tick_1hz) begin
          idle_d = idle_inc;
          if (idle_inc == TIMEOUT_V) state_d = ST_RUN;
        end
      end

      ST_SET_MIN: begin
        if (bus.tick_1hz) blink_d = ~blink_q;
        if (bus.btn_mode) begin
          state_d = ST_COMMIT;
          idle_d  = '0;
        end else if (bus.btn_inc) begin
          set_min_d = inc_min(set_min_q);
          idle_d    = '0;
        end else if (bus.tick_1hz) begin
          idle_d = idle_inc;
          if (idle_inc == TIMEOUT_V) state_d = ST_RUN;
        end
      end

      ST_COMMIT: begin
        // Single load cycle; buttons here are deliberately ignored.
        state_d = ST_RUN;
      end

      default: state_d = ST_RUN;
    endcase

    // Blink only has meaning while a field is being edited.
    if (state_d == ST_RUN || state_d == ST_COMMIT) blink_d = 1'b0;

    run_en_d = (state_d == ST_RUN);
    load_d   = (state_d == ST_COMMIT);
    unique case (state_d)
      ST_SET_HR:  edit_field_d = FIELD_HOUR;
      ST_SET_MIN: edit_field_d = FIELD_MIN;
      default:    edit_field_d = FIELD_NONE;
    endcase
  end

  // State and output registers; reset aborts any session with no load pulse.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= ST_RUN;
      set_hour_q   <= '0;
      set_min_q    <= '0;
      idle_q       <= '0;
      blink_q      <= 1'b0;
      run_en_q     <= 1'b1;
      load_q       <= 1'b0;
      edit_field_q <= FIELD_NONE;
    end else begin
      state_q      <= state_d;
      set_hour_q   <= set_hour_d;
      set_min_q    <= set_min_d;
      idle_q       <= idle_d;
      blink_q      <= blink_d;
      run_en_q     <= run_en_d;
      load_q       <= load_d;
      edit_field_q <= edit_field_d;
    end
  end

  assign bus.run_en     = run_en_q;
  assign bus.load       = load_q;
  assign bus.set_hour   = set_hour_q;
  assign bus.set_min    = set_min_q;
  assign bus.edit_field = edit_field_q;
  assign bus.blink      = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with hand-computed expectations.
module tb_clock_set_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   load_cnt;
  int   load_base;

  clock_set_ctrl_if bus ();

  clock_set_ctrl #(.TIMEOUT_S(30)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running count of load pulses, sampled mid-cycle.
  initial load_cnt = 0;
  always @(negedge clk) if (bus.load === 1'b1) load_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present buttons/tick for one clock edge, then release them 1ns after it.
  task automatic step(input logic m, input logic i, input logic t);
    bus.btn_mode = m;
    bus.btn_inc  = i;
    bus.tick_1hz = t;
    @(posedge clk);
    #1;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    bus.tick_1hz = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    bus.tick_1hz = 1'b0;
    bus.cur_hour = 5'd0;
    bus.cur_min  = 6'd0;
    rst_n        = 1'b1;

    // Reset, with a mode press present that must be overridden.
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check_eq("rst_run_en", bus.run_en, 1);
    check_eq("rst_load", bus.load, 0);
    check_eq("rst_hour", bus.set_hour, 0);
    check_eq("rst_min", bus.set_min, 0);
    check_eq("rst_field", bus.edit_field, 0);
    check_eq("rst_blink", bus.blink, 0);
    check_eq("rst_idle", dut.idle_q, 0);
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    check_eq("run_tick_blink", bus.blink, 0);

    // Full set sequence 9:15 -> 12:17.
    bus.cur_hour = 5'd9;
    bus.cur_min  = 6'd15;
    step(1'b0, 1'b1, 1'b0);
    check_eq("run_inc_ignored", bus.set_hour, 0);
    step(1'b1, 1'b0, 1'b0);
    check_eq("enter_hr_field", bus.edit_field, 1);
    check_eq("enter_hr_run_en", bus.run_en, 0);
    check_eq("capture_hour", bus.set_hour, 9);
    check_eq("capture_min", bus.set_min, 15);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0);
    check_eq("hour_plus3", bus.set_hour, 12);
    step(1'b1, 1'b0, 1'b0);
    check_eq("enter_min_field", bus.edit_field, 2);
    for (int k = 0; k < 2; k++) step(1'b0, 1'b1, 1'b0);
    check_eq("min_plus2", bus.set_min, 17);
    check_eq("no_load_yet", bus.load, 0);
    load_base = load_cnt;
    step(1'b1, 1'b0, 1'b0);
    check_eq("commit_load", bus.load, 1);
    check_eq("commit_run_en", bus.run_en, 0);
    check_eq("commit_hour", bus.set_hour, 12);
    check_eq("commit_min", bus.set_min, 17);
    step(1'b1, 1'b1, 1'b0);
    check_eq("after_commit_run_en", bus.run_en, 1);
    check_eq("after_commit_load", bus.load, 0);
    check_eq("after_commit_field", bus.edit_field, 0);
    check_eq("one_load_pulse", load_cnt - load_base, 1);

    // Wrap behaviour: hour 22 -> 23,0,1 and minute 58 -> 59,0.
    bus.cur_hour = 5'd22;
    bus.cur_min  = 6'd58;
    step(1'b1, 1'b0, 1'b0);
    check_eq("wrap_start_hour", bus.set_hour, 22);
    step(1'b0, 1'b1, 1'b0);
    check_eq("wrap_hour_23", bus.set_hour, 23);
    step(1'b0, 1'b1, 1'b0);
    check_eq("wrap_hour_0", bus.set_hour, 0);
    step(1'b0, 1'b1, 1'b0);
    check_eq("wrap_hour_1", bus.set_hour, 1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check_eq("wrap_min_59", bus.set_min, 59);
    step(1'b0, 1'b1, 1'b0);
    check_eq("wrap_min_0", bus.set_min, 0);

    // Mode and inc together in minute edit: commit wins, minute unchanged.
    step(1'b1, 1'b1, 1'b0);
    check_eq("both_load", bus.load, 1);
    check_eq("both_min_kept", bus.set_min, 0);
    check_eq("both_hour_kept", bus.set_hour, 1);
    step(1'b0, 1'b0, 1'b0);
    check_eq("both_back_run", bus.run_en, 1);

    // Inactivity timeout after 30 ticks in hour edit.
    bus.cur_hour = 5'd5;
    bus.cur_min  = 6'd6;
    load_base = load_cnt;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check_eq("to_blink_first", bus.blink, 1);
    for (int k = 0; k < 28; k++) step(1'b0, 1'b0, 1'b1);
    check_eq("to_29_field", bus.edit_field, 1);
    check_eq("to_29_run_en", bus.run_en, 0);
    check_eq("to_29_blink", bus.blink, 1);
    check_eq("to_29_idle", dut.idle_q, 29);
    step(1'b0, 1'b0, 1'b1);
    check_eq("to_30_run_en", bus.run_en, 1);
    check_eq("to_30_field", bus.edit_field, 0);
    check_eq("to_30_blink", bus.blink, 0);
    check_eq("to_hour_kept", bus.set_hour, 5);
    check_eq("to_no_load", load_cnt - load_base, 0);

    // Button on the 30th tick keeps the session alive.
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 29; k++) step(1'b0, 1'b0, 1'b1);
    check_eq("race_idle_29", dut.idle_q, 29);
    step(1'b0, 1'b1, 1'b1);
    check_eq("race_field", bus.edit_field, 1);
    check_eq("race_idle_clr", dut.idle_q, 0);
    check_eq("race_blink", bus.blink, 0);
    check_eq("race_hour", bus.set_hour, 6);
    step(1'b0, 1'b0, 1'b1);
    check_eq("race_idle_1", dut.idle_q, 1);
    check_eq("race_blink_1", bus.blink, 1);

    // Reset mid-edit aborts with no load.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check_eq("mid_min_7", bus.set_min, 7);
    load_base = load_cnt;
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    rst_n = 1'b0;
    check_eq("mid_rst_run_en", bus.run_en, 1);
    check_eq("mid_rst_load", bus.load, 0);
    check_eq("mid_rst_hour", bus.set_hour, 0);
    check_eq("mid_rst_min", bus.set_min, 0);
    check_eq("mid_rst_field", bus.edit_field, 0);
    step(1'b0, 1'b0, 1'b0);
    check_eq("mid_rst_no_load", load_cnt - load_base, 0);
    check_eq("mid_rst_stay_run", bus.run_en, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
